// File: rtl/cam_fifo_reader.sv
// cam_fifo_reader: OV7670 + AL422B frame grabber.
// The FIFO is armed for exactly one frame between two VSYNC rising edges.
// The frame is then read back as RGB565 byte pairs, optionally decimated by
// 2^SCALE_LOG2 in both axes, and written out through a single-cycle pixel
// write port.
// Optional feature: define CAM_GRAY_EN to emit luma instead of RGB333.
module cam_fifo_reader #(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int SCALE_LOG2  = 1,
  parameter int ADDR_W      = 15,
  parameter int RRST_CYCLES = 4,
  parameter int MAX_FRAMES  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ov_vsync,
  input  logic [7:0]        cam_data,
  input  logic              work_en,
  output logic              fifo_wen,
  output logic              fifo_wrst,
  output logic              fifo_rrst,
  output logic              fifo_oe,
  output logic              rclk_en,
  output logic              px_we,
  output logic [ADDR_W-1:0] px_addr,
  output logic [8:0]        px_data,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int C_W = $clog2(RRST_CYCLES + 1);
  localparam int OUT_W = IMG_W >> SCALE_LOG2;
  localparam logic [31:0] SMASK = (32'd1 << SCALE_LOG2) - 32'd1;
  localparam logic [16:0] MAXF = 17'(MAX_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_CAP, S_RRST, S_RHI, S_RLO, S_DONE
  } state_t;

  state_t r_state, w_nxt;

  logic r_vs_meta, r_vs_sync, r_vs_prev, r_vs_rise;
  logic [C_W-1:0] r_rcnt;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [7:0] r_hi;
  logic r_we, r_wen, r_wrst, r_done;
  logic [ADDR_W-1:0] r_addr;
  logic [8:0] r_data;
  logic [15:0] r_fcnt;

  logic w_room, w_xlast, w_ylast, w_last, w_keep;
  logic w_busy, w_rclk, w_rrst;
  logic [ADDR_W-1:0] w_addr;
  logic [8:0] w_pix;

  assign w_room  = (MAX_FRAMES == 0) || ({1'b0, r_fcnt} < MAXF);
  assign w_xlast = (r_x == X_W'(IMG_W - 1));
  assign w_ylast = (r_y == Y_W'(IMG_H - 1));
  assign w_last  = w_xlast && w_ylast;
  assign w_keep  = ((32'(r_x) & SMASK) == 32'd0) && ((32'(r_y) & SMASK) == 32'd0);
  assign w_addr  = ADDR_W'((32'(r_y) >> SCALE_LOG2) * 32'(OUT_W) + (32'(r_x) >> SCALE_LOG2));

`ifdef CAM_GRAY_EN
  // Luma approximation: R5 + G6 + B5 fits in 7 bits, shifted up to 8-bit scale.
  logic [6:0] w_sum;
  assign w_sum = 7'(r_hi[7:3]) + 7'({r_hi[2:0], cam_data[7:5]}) + 7'(cam_data[4:0]);
  assign w_pix = {1'b0, w_sum, 1'b0};
`else
  // RGB333 keeps the top three bits of each RGB565 channel.
  logic w_unused;
  assign w_pix    = {r_hi[7:5], r_hi[2:0], cam_data[4:2]};
  assign w_unused = ^{r_hi[4:3], cam_data[7:5], cam_data[1:0]};
`endif

  // VSYNC synchroniser and registered rising-edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
      r_vs_rise <= 1'b0;
    end else begin
      r_vs_meta <= ov_vsync;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
      r_vs_rise <= r_vs_sync & ~r_vs_prev;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  // Next-state logic and state-decoded FIFO read controls.
  always_comb begin
    w_nxt  = r_state;
    w_busy = 1'b1;
    w_rclk = 1'b0;
    w_rrst = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (work_en && w_room) w_nxt = S_ARM;
      end
      S_ARM:  if (r_vs_rise) w_nxt = S_CAP;
      S_CAP:  if (r_vs_rise) w_nxt = S_RRST;
      S_RRST: begin
        w_rrst = 1'b0;
        w_rclk = 1'b1;
        if (r_rcnt == C_W'(RRST_CYCLES - 1)) w_nxt = S_RHI;
      end
      S_RHI: begin
        w_rclk = 1'b1;
        w_nxt  = S_RLO;
      end
      S_RLO: begin
        w_rclk = 1'b1;
        w_nxt  = w_last ? S_DONE : S_RHI;
      end
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Write-side FIFO strobes, readout counters, pixel output and frame count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rcnt <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_hi   <= '0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_wen  <= 1'b0;
      r_wrst <= 1'b1;
      r_done <= 1'b0;
      r_fcnt <= '0;
    end else begin
      r_we   <= 1'b0;
      r_wrst <= 1'b1;
      r_done <= 1'b0;
      r_rcnt <= '0;
      unique case (r_state)
        S_ARM: if (r_vs_rise) begin
          r_wrst <= 1'b0;
          r_wen  <= 1'b1;
        end
        S_CAP: if (r_vs_rise) r_wen <= 1'b0;
        S_RRST: begin
          r_rcnt <= r_rcnt + 1'b1;
          r_x    <= '0;
          r_y    <= '0;
        end
        S_RHI: r_hi <= cam_data;
        S_RLO: begin
          if (w_keep) begin
            r_we   <= 1'b1;
            r_addr <= w_addr;
            r_data <= w_pix;
          end
          if (w_xlast) begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          if (r_fcnt != 16'hFFFF) r_fcnt <= r_fcnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign fifo_wen   = r_wen;
  assign fifo_wrst  = r_wrst;
  assign fifo_rrst  = w_rrst;
  assign fifo_oe    = 1'b0;
  assign rclk_en    = w_rclk;
  assign px_we      = r_we;
  assign px_addr    = r_addr;
  assign px_data    = r_data;
  assign busy       = w_busy;
  assign frame_done = r_done;
  assign frame_cnt  = r_fcnt;

endmodule

// File: tb/tb_cam_fifo_reader.sv
// Bench for cam_fifo_reader: two instances (full-res and 2x decimated) share
// the camera/FIFO stimulus; a pixel-list model predicts every write.
module tb_cam_fifo_reader;
  localparam int W = 8, H = 4, RR = 4;

  logic clk = 1'b0, rst = 1'b0, ov_vsync = 1'b0, work_en = 1'b0;
  logic [7:0] cam_data;

  logic a_wen, a_wrst, a_rrst, a_oe, a_rclk, a_we, a_busy, a_done;
  logic [7:0] a_addr;
  logic [8:0] a_data;
  logic [15:0] a_cnt;
  logic b_wen, b_wrst, b_rrst, b_oe, b_rclk, b_we, b_busy, b_done;
  logic [7:0] b_addr;
  logic [8:0] b_data;
  logic [15:0] b_cnt;

  cam_fifo_reader #(.IMG_W(W), .IMG_H(H), .SCALE_LOG2(0), .ADDR_W(8),
                    .RRST_CYCLES(RR), .MAX_FRAMES(2)) u_a (
    .clk(clk), .rst(rst), .ov_vsync(ov_vsync), .cam_data(cam_data), .work_en(work_en),
    .fifo_wen(a_wen), .fifo_wrst(a_wrst), .fifo_rrst(a_rrst), .fifo_oe(a_oe),
    .rclk_en(a_rclk), .px_we(a_we), .px_addr(a_addr), .px_data(a_data),
    .busy(a_busy), .frame_done(a_done), .frame_cnt(a_cnt));

  cam_fifo_reader #(.IMG_W(W), .IMG_H(H), .SCALE_LOG2(1), .ADDR_W(8),
                    .RRST_CYCLES(RR), .MAX_FRAMES(2)) u_b (
    .clk(clk), .rst(rst), .ov_vsync(ov_vsync), .cam_data(cam_data), .work_en(work_en),
    .fifo_wen(b_wen), .fifo_wrst(b_wrst), .fifo_rrst(b_rrst), .fifo_oe(b_oe),
    .rclk_en(b_rclk), .px_we(b_we), .px_addr(b_addr), .px_data(b_data),
    .busy(b_busy), .frame_done(b_done), .frame_cnt(b_cnt));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---- model: image content, colour conversion, expected write lists ----
  int cur_pat = 0;

  function automatic logic [15:0] pix(input int pat, input int k);
    if (pat == 0) return 16'(k);
    if (k == 0) return 16'hFFFF;
    if (k == 1) return 16'hF800;
    return 16'(k * 2113) ^ 16'h5A3C;
  endfunction

  function automatic logic [7:0] byte_at(input int pat, input int i);
    logic [15:0] p;
    p = pix(pat, i / 2);
    return (i % 2 == 0) ? p[15:8] : p[7:0];
  endfunction

  function automatic logic [8:0] cvt(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]); g = int'(p[10:5]); b = int'(p[4:0]);
`ifdef CAM_GRAY_EN
    return 9'((r + g + b) * 2);
`else
    return 9'((r / 4) * 64 + (g / 8) * 8 + (b / 4));
`endif
  endfunction

  typedef struct { int addr; logic [8:0] data; } wr_t;
  wr_t qa[$], qb[$];
  wr_t ea, eb;

  // FIFO read pointer: cleared by read reset, advanced by each gated RCLK.
  int rp = 0;
  always @(posedge clk) begin
    if (!a_rrst) rp <= 0;
    else if (a_rclk) rp <= rp + 1;
  end
  always_comb cam_data = byte_at(cur_pat, rp);

  // ---- compare process ----
  int cyc = 0, rrst_t = 0, a_last = 0, na = 0, nb = 0, busy_cnt = 0, wrst_lows = 0;
  logic pa = 1'b0, pb = 1'b0, prrst = 1'b1, pwrst = 1'b1;
  logic [8:0] a_first [2];
  logic [8:0] b_third = '0;

  always @(negedge clk) begin
    cyc++;
    if (a_we) begin
      chk("we_gap_a", 32'(pa), 0);
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_we_a actual addr=%0h required no write", a_addr);
      end else begin
        ea = qa.pop_front();
        chk("addr_a", 32'(a_addr), ea.addr);
        chk("data_a", 32'(a_data), 32'(ea.data));
      end
      if (na < 2) a_first[na] = a_data;
      na++;
      a_last = cyc;
    end
    if (b_we) begin
      chk("we_gap_b", 32'(pb), 0);
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL extra_we_b actual addr=%0h required no write", b_addr);
      end else begin
        eb = qb.pop_front();
        chk("addr_b", 32'(b_addr), eb.addr);
        chk("data_b", 32'(b_data), 32'(eb.data));
      end
      if (nb == 2) b_third = b_data;
      nb++;
    end
    if (!a_rrst && prrst) rrst_t = cyc;
    if (!a_wrst) begin
      wrst_lows++;
      chk("wrst_width", 32'(pwrst), 1);
    end
    if (a_busy) busy_cnt++;
    if (a_done) begin
      chk("done_after_we", cyc - a_last, 1);
      chk("readout_len", cyc - rrst_t, RR + 2 * W * H + 1);
      chk("qa_empty", qa.size(), 0);
      chk("qb_empty", qb.size(), 0);
    end
    pa = a_we; pb = b_we; prrst = a_rrst; pwrst = a_wrst;
  end

  // ---- stimulus ----
  task automatic vsync_pulse();
    @(negedge clk) ov_vsync = 1'b1;
    repeat (4) @(negedge clk);
    ov_vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic load_frame(input int pat);
    wr_t e;
    cur_pat = pat; na = 0; nb = 0;
    qa.delete(); qb.delete();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        e.data = cvt(pix(pat, y * W + x));
        e.addr = y * W + x;
        qa.push_back(e);
        if (x % 2 == 0 && y % 2 == 0) begin
          e.addr = (y / 2) * (W / 2) + x / 2;
          qb.push_back(e);
        end
      end
  endtask

  task automatic run_frame(input int pat);
    int got;
    load_frame(pat);
    vsync_pulse();
    vsync_pulse();
    got = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (a_done) begin got = 1; break; end
    end
    chk("frame_done_seen", got, 1);
    @(negedge clk);
  endtask

  initial begin
    int found;
    // reset held with work_en high
    work_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wen", 32'(a_wen), 0);
    chk("rst_wrst", 32'(a_wrst), 1);
    chk("rst_rrst", 32'(a_rrst), 1);
    chk("rst_oe", 32'(a_oe), 0);
    chk("rst_rclk", 32'(a_rclk), 0);
    chk("rst_we", 32'(a_we), 0);
    chk("rst_addr", 32'(a_addr), 0);
    chk("rst_data", 32'(a_data), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_cnt", 32'(a_cnt), 0);
    chk("rst_busy_b", 32'(b_busy), 0);

    // idle with work_en low: VSYNC must not start anything
    work_en = 1'b0;
    @(negedge clk) rst = 1'b1;
    wrst_lows = 0; busy_cnt = 0;
    vsync_pulse();
    chk("idle_busy", busy_cnt, 0);
    chk("idle_wrst", wrst_lows, 0);

    // frame 1: index pattern
    work_en = 1'b1;
    run_frame(0);
    chk("f1_cnt", 32'(a_cnt), 1);
    chk("f1_na", na, 32);
    chk("f1_nb", nb, 8);
`ifdef CAM_GRAY_EN
    chk("f1_b_third", 32'(b_third), 32'h008);
`else
    chk("f1_b_third", 32'(b_third), 32'h001);
`endif

    // frame 2: colour corner cases
    run_frame(1);
`ifdef CAM_GRAY_EN
    chk("px_ffff", 32'(a_first[0]), 32'h0FA);
    chk("px_f800", 32'(a_first[1]), 32'h03E);
`else
    chk("px_ffff", 32'(a_first[0]), 32'h1FF);
    chk("px_f800", 32'(a_first[1]), 32'h1C0);
`endif
    chk("f2_cnt", 32'(a_cnt), 2);

    // frame limit reached: further VSYNCs are ignored
    qa.delete(); qb.delete();
    busy_cnt = 0; wrst_lows = 0;
    repeat (4) vsync_pulse();
    chk("lim_cnt", 32'(a_cnt), 2);
    chk("lim_cnt_b", 32'(b_cnt), 2);
    chk("lim_busy", busy_cnt, 0);
    chk("lim_wrst", wrst_lows, 0);

    // reset clears the count, then abort a frame mid-readout
    rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    load_frame(0);
    vsync_pulse();
    vsync_pulse();
    found = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rp == 21) begin found = 1; break; end
    end
    chk("reach_px10", found, 1);
    chk("pre_rst_busy", 32'(a_busy), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(a_busy), 0);
    chk("mid_rst_rclk", 32'(a_rclk), 0);
    chk("mid_rst_rrst", 32'(a_rrst), 1);
    chk("mid_rst_wen", 32'(a_wen), 0);
    chk("mid_rst_we", 32'(a_we), 0);
    chk("mid_rst_addr", 32'(a_addr), 0);
    chk("mid_rst_data", 32'(a_data), 0);
    chk("mid_rst_cnt", 32'(a_cnt), 0);
    chk("mid_rst_addr_b", 32'(b_addr), 0);
    qa.delete(); qb.delete();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);

    // next VSYNC must arm the FIFO again
    ov_vsync = 1'b1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!a_wrst) begin found = 1; break; end
    end
    chk("post_rst_wrst", found, 1);
    @(negedge clk);
    chk("post_rst_wrst_hi", 32'(a_wrst), 1);
    chk("post_rst_wen", 32'(a_wen), 1);
    ov_vsync = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
